// File: rtl/mixer_axil_pkg.sv
// Shared constants and FSM state types for the mixer AXI4-Lite register slave.
package mixer_axil_pkg;

  localparam int NUM_REGS = 4;

  localparam logic [3:0] REG0_OFFSET = 4'h0;
  localparam logic [3:0] REG1_OFFSET = 4'h4;
  localparam logic [3:0] REG2_OFFSET = 4'h8;
  localparam logic [3:0] REG3_OFFSET = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

endpackage

// File: rtl/mixer_axil_slave.sv
// AXI4-Lite slave exposing four 32-bit RW registers to the mixer datapath.
// Optional MIXER_AXIL_SLVERR_EN: offsets >= 0x10 get SLVERR instead of aliasing.
//
// state  | meaning
// W_IDLE | collecting AW and W halves independently
// W_RESP | register written, BVALID held until BREADY
// R_IDLE | ARREADY high, waiting for an address
// R_DATA | RDATA/RRESP held until RREADY
module mixer_axil_slave
  import mixer_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] regs_o
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;

  wstate_t w_state, w_state_nxt;
  rstate_t r_state, r_state_nxt;

  logic          aw_held, w_held;
  logic [AW-1:0] aw_addr_q;
  logic [31:0]   w_data_q;
  logic [3:0]    w_strb_q;
  logic [31:0]   regs [NUM_REGS];
  logic [1:0]    bresp_q, rresp_q;
  logic [31:0]   rdata_q;

  logic          aw_rdy, w_rdy, ar_rdy, aw_hs, w_hs, ar_hs, do_write, wr_en;
  logic          bvalid, rvalid;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strb;
  logic [1:0]    wr_resp, rd_resp;
  logic [31:0]   rd_data;
  logic          unused_ok;

  // Readies are gated by ARESETN so they read low while reset is asserted.
  always_comb begin
    w_state_nxt = w_state;
    aw_rdy      = 1'b0;
    w_rdy       = 1'b0;
    bvalid      = 1'b0;
    do_write    = 1'b0;
    case (w_state)
      W_IDLE: begin
        aw_rdy = ARESETN && !aw_held;
        w_rdy  = ARESETN && !w_held;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (S_AXI_BREADY) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
    aw_hs = S_AXI_AWVALID && aw_rdy;
    w_hs  = S_AXI_WVALID && w_rdy;
    if (w_state == W_IDLE && (aw_held || aw_hs) && (w_held || w_hs)) begin
      do_write    = 1'b1;
      w_state_nxt = W_RESP;
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    ar_rdy      = 1'b0;
    rvalid      = 1'b0;
    case (r_state)
      R_IDLE: ar_rdy = ARESETN;
      R_DATA: begin
        rvalid = 1'b1;
        if (S_AXI_RREADY) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
    ar_hs = S_AXI_ARVALID && ar_rdy;
    if (ar_hs) r_state_nxt = R_DATA;
  end

  assign wr_addr = aw_held ? aw_addr_q : S_AXI_AWADDR;
  assign wr_data = w_held  ? w_data_q  : S_AXI_WDATA;
  assign wr_strb = w_held  ? w_strb_q  : S_AXI_WSTRB;

`ifdef MIXER_AXIL_SLVERR_EN
  assign wr_en   = do_write && !(|wr_addr[AW-1:4]);
  assign wr_resp = (|wr_addr[AW-1:4]) ? RESP_SLVERR : RESP_OKAY;
  assign rd_resp = (|S_AXI_ARADDR[AW-1:4]) ? RESP_SLVERR : RESP_OKAY;
  assign rd_data = (|S_AXI_ARADDR[AW-1:4]) ? 32'h0 : regs[S_AXI_ARADDR[3:2]];
`else
  assign wr_en   = do_write;
  assign wr_resp = RESP_OKAY;
  assign rd_resp = RESP_OKAY;
  assign rd_data = regs[S_AXI_ARADDR[3:2]];
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state   <= W_IDLE;
      r_state   <= R_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
      if (do_write) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bresp_q <= wr_resp;
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= S_AXI_WDATA;
          w_strb_q <= S_AXI_WSTRB;
        end
      end
      if (wr_en) begin
        for (int b = 0; b < 4; b++)
          if (wr_strb[b]) regs[wr_addr[3:2]][8*b +: 8] <= wr_data[8*b +: 8];
      end
      // Captured from the pre-edge register value: same-cycle writes are not visible.
      if (ar_hs) begin
        rdata_q <= rd_data;
        rresp_q <= rd_resp;
      end
    end
  end

  assign S_AXI_AWREADY = aw_rdy;
  assign S_AXI_WREADY  = w_rdy;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = ar_rdy;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign regs_o        = {regs[3], regs[2], regs[1], regs[0]};

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr, S_AXI_ARADDR};

endmodule

// File: tb/tb_mixer_axil_slave.sv
// Self-checking bench for mixer_axil_slave: directed scenarios plus randomized traffic
// against an array-based register model.
module tb_mixer_axil_slave;

  logic         ACLK = 1'b0;
  logic         ARESETN;
  logic [5:0]   S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]   S_AXI_AWPROT, S_AXI_ARPROT;
  logic         S_AXI_AWVALID, S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID, S_AXI_BREADY;
  logic         S_AXI_ARVALID, S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID, S_AXI_RREADY;
  logic [127:0] regs_o;

  int tests = 0;
  int fails = 0;
  logic [31:0] model [4];

  always #5 ACLK = ~ACLK;

  mixer_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .regs_o(regs_o)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(input logic [5:0] a);
`ifdef MIXER_AXIL_SLVERR_EN
    return a >= 6'h10;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int slot(input logic [5:0] a);
    return (int'(a) / 4) % 4;
  endfunction

  function automatic logic [127:0] model_flat();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  function automatic void model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    if (is_err(a)) return;
    mask = 0;
    for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
    model[slot(a)] = (model[slot(a)] & ~mask) | (d & mask);
  endfunction

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
    int cyc = 0;
    bit aw_done = 0, w_done = 0, aw_fire, w_fire;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWPROT = 3'($urandom_range(0, 7));
    while (!(aw_done && w_done) && cyc < 40) begin
      S_AXI_AWVALID = !aw_done && cyc >= aw_dly;
      S_AXI_WVALID  = !w_done && cyc >= w_dly;
      #1;
      aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
      w_fire  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (aw_fire) aw_done = 1;
      if (w_fire) w_done = 1;
      cyc++;
      if (w_done && !aw_done) check("wready_low_while_data_held", S_AXI_WREADY, 0);
      if (aw_done && !w_done) check("awready_low_while_addr_held", S_AXI_AWREADY, 0);
    end
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    check("write_accepted", {aw_done, w_done}, 2'b11);
    check("bvalid_latency", S_AXI_BVALID, 1);
    model_write(a, d, s);
    for (int i = 0; i < b_dly; i++) begin
      check("bvalid_hold", S_AXI_BVALID, 1);
      check("aw_w_ready_low_in_resp", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
      @(posedge ACLK); #1;
    end
    check("bresp", S_AXI_BRESP, is_err(a) ? 2'b10 : 2'b00);
    S_AXI_BREADY = 1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 0;
    check("bvalid_clear", S_AXI_BVALID, 0);
    check("ready_after_bresp", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
    check("regs_o_after_write", regs_o, model_flat());
  endtask

  task automatic axi_read_check(input logic [5:0] a, input int r_dly);
    int cyc = 0;
    bit fired = 0;
    logic [31:0] exp_d, got_d;
    logic [1:0]  exp_r, got_r;
    exp_d = is_err(a) ? 32'h0 : model[slot(a)];
    exp_r = is_err(a) ? 2'b10 : 2'b00;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1;
    S_AXI_ARPROT = 3'($urandom_range(0, 7));
    while (!fired && cyc < 40) begin
      #1;
      fired = S_AXI_ARREADY;
      @(posedge ACLK); #1;
      cyc++;
    end
    S_AXI_ARVALID = 0;
    check("ar_accepted", fired, 1);
    check("rvalid_latency", S_AXI_RVALID, 1);
    got_d = S_AXI_RDATA; got_r = S_AXI_RRESP;
    check("rdata", got_d, exp_d);
    check("rresp", got_r, exp_r);
    for (int i = 0; i < r_dly; i++) begin
      @(posedge ACLK); #1;
      check("rdata_stable", {S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP}, {1'b1, got_d, got_r});
    end
    S_AXI_RREADY = 1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 0;
    check("rvalid_clear", S_AXI_RVALID, 0);
  endtask

  initial begin
    ARESETN = 0;
    S_AXI_AWADDR = 0; S_AXI_AWPROT = 0; S_AXI_AWVALID = 0;
    S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
    S_AXI_ARADDR = 0; S_AXI_ARPROT = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    for (int i = 0; i < 4; i++) model[i] = 0;

    #12;
    check("reset_handshake_outputs",
          {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID}, 5'b0);
    check("reset_rdata_resp", {S_AXI_RDATA, S_AXI_BRESP, S_AXI_RRESP}, 36'h0);
    check("reset_regs", regs_o, 128'h0);
    @(posedge ACLK); #1;
    ARESETN = 1;
    #1;
    check("ready_after_reset", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

    // Basic write/readback of all four registers.
    for (int i = 0; i < 4; i++) axi_write(6'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_read_check(6'(4 * i), i);
    check("regs_o_pattern", regs_o, 128'h00000004_00000003_00000002_00000001);

    // Data three cycles ahead of address.
    axi_write(6'h08, 32'hDEADBEEF, 4'hF, 3, 0, 0);
    check("reg2_w_first", regs_o[95:64], 32'hDEADBEEF);

    // Byte strobes.
    axi_write(6'h00, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_write(6'h00, 32'h12345678, 4'b0101, 0, 0, 0);
    check("reg0_strobe", regs_o[31:0], 32'hFF34FF78);

    // Response back-pressure, then an immediate second write.
    axi_write(6'h0C, 32'hCAFEF00D, 4'hF, 0, 0, 10);
    axi_write(6'h0C, 32'h0BADC0DE, 4'hF, 0, 0, 0);

    // Simultaneous read and write of the same register.
    axi_write(6'h04, 32'h0000000A, 4'hF, 0, 2, 0);
    S_AXI_AWADDR = 6'h04; S_AXI_WDATA = 32'h0000000B; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 6'h04;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_ARVALID = 1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    check("concurrent_rdata_old", {S_AXI_RVALID, S_AXI_RDATA}, {1'b1, 32'h0000000A});
    check("concurrent_bvalid", S_AXI_BVALID, 1);
    model_write(6'h04, 32'h0000000B, 4'hF);
    S_AXI_BREADY = 1; S_AXI_RREADY = 1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 0; S_AXI_RREADY = 0;
    check("concurrent_done", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
    axi_read_check(6'h04, 0);
    check("reg1_new", regs_o[63:32], 32'h0000000B);

    // Out-of-range offset: alias by default, SLVERR with the option enabled.
    axi_write(6'h20, 32'h5A5A5A5A, 4'hF, 1, 0, 1);
    axi_read_check(6'h20, 1);
    axi_read_check(6'h00, 0);

    // Reset while a read response is pending.
    S_AXI_ARADDR = 6'h08; S_AXI_ARVALID = 1;
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 0;
    check("rvalid_before_reset", S_AXI_RVALID, 1);
    ARESETN = 0;
    #2;
    for (int i = 0; i < 4; i++) model[i] = 0;
    check("rvalid_in_reset", S_AXI_RVALID, 0);
    check("regs_cleared", regs_o, model_flat());
    check("readies_in_reset", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    @(posedge ACLK); #1;
    ARESETN = 1;
    #1;
    check("ready_after_midreset", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_RVALID}, 4'b1110);
    axi_read_check(6'h08, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      logic [5:0] a;
      a = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        axi_read_check(a, $urandom_range(0, 2));
    end
    check("regs_final", regs_o, model_flat());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
